par8_slave: RTL and testbench
=============================

PAR8_SLAVE -- requirements
Module: par8_slave

Interface
REQ-001 Parameter SYNC0, default 8'hB8, is the first sync word.
REQ-002 Parameter SYNC1, default 8'h8B, is the second sync word.
REQ-003 Port clk, input, 1 bit: system clock (100 MHz).
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 Port bus_clk, input, 1 bit: par8 strobe from master, asynchronous to clk.
REQ-006 Port bus_rnw, input, 1 bit: master direction; 1 = master reads, 0 = master writes.
REQ-007 Port bus_data_in, input, 8 bits: pad-side data from master.
REQ-008 Port bus_data_out, output, 8 bits: data driven to master.
REQ-009 Port bus_data_oe, output, 1 bit: pad tristate enable; the tristate buffer is outside this block.
REQ-010 Port synced, output, 1 bit: high once the sync sequence has been detected.
REQ-011 Port rx_data, output, 8 bits: received byte.
REQ-012 Port rx_valid, output, 1 bit: one-cycle strobe qualifying rx_data; there is no backpressure.
REQ-013 Port tx_data, input, 8 bits: byte offered for master read.
REQ-014 Port tx_valid, input, 1 bit: tx_data is available.
REQ-015 Port tx_ready, output, 1 bit: one-cycle strobe; tx_data was consumed this cycle.
REQ-016 Port tx_underrun, output, 1 bit: sticky flag; a read strobe occurred with tx_valid low.
REQ-017 Port rx_count, output, 16 bits: count of received bytes.
REQ-018 Port tx_count, output, 16 bits: count of transmitted bytes.

Function
REQ-019 bus_clk, bus_rnw and bus_data_in SHALL each pass through a 2-flop synchronizer to give s_clk, s_rnw and s_data; a third register on s_clk SHALL be used for edge detection.
REQ-020 The sync FSM SHALL have three states: UNSYNC, SAW0 and SYNCED; it evaluates only when s_clk=1 and s_rnw=0.
REQ-021 UNSYNC SHALL go to SAW0 when s_data==SYNC0; otherwise it stays in UNSYNC.
REQ-022 SAW0 SHALL go to SYNCED when s_data==SYNC1, stay in SAW0 when s_data==SYNC0, and go to UNSYNC for any other value.
REQ-023 SYNCED SHALL be held until reset; synced=1 exactly in SYNCED.
REQ-024 Write: on an s_clk rising edge with s_rnw=0 in SYNCED, rx_data SHALL load s_data and rx_valid SHALL pulse for 1 cycle, 3 clk edges after the bus_clk pin rise.
REQ-025 Read: on an s_clk falling edge with s_rnw=1 in SYNCED and tx_valid=1, bus_data_out SHALL load tx_data and tx_ready SHALL pulse for 1 cycle in the same cycle.
REQ-026 Read underrun: on an s_clk falling edge with s_rnw=1 and tx_valid=0, bus_data_out SHALL load 8'h00, tx_underrun SHALL set, and tx_ready SHALL stay 0.
REQ-027 bus_data_out SHALL hold its value until the next qualifying falling edge.
REQ-028 bus_data_oe SHALL equal s_rnw AND synced, registered; it drops within 3 clk of bus_rnw falling.
REQ-029 Edges seen while not SYNCED SHALL produce no rx_valid, no tx_ready and no counter change.
REQ-030 A rising edge with s_rnw=1, or a falling edge with s_rnw=0, SHALL be ignored.
REQ-031 rx_count and tx_count SHALL increment on rx_valid and tx_ready respectively, wrapping 16'hFFFF to 0.

Reset
REQ-032 While reset=0, all synchronizer flops SHALL be 0 and the FSM SHALL be in UNSYNC.
REQ-033 While reset=0, synced, rx_valid, tx_ready, tx_underrun and bus_data_oe SHALL be 0, and rx_data, bus_data_out, rx_count and tx_count SHALL be 0.
REQ-034 A reset asserted mid-transfer SHALL abort the transfer with no strobe; the master must resend SYNC0/SYNC1.

Configuration
REQ-035 Macro PAR8_STATS_EN: when defined, rx_count and tx_count SHALL be live counters per REQ-031; when undefined, both SHALL be tied to 16'h0000 and no counter flops SHALL be synthesized.

Verification
REQ-036 Release reset; drive bus_clk=1, bus_rnw=0 and bus_data_in=B8 for 3 clk, then 8B for 3 clk -> synced=1 within 3 clk of 8B; no rx_valid.
REQ-037 After sync, write 8'h05, 8'h00, 8'hB8 with bus_clk low/high per 3 clk -> three rx_valid pulses carrying 05, 00, B8, each 3 clk after the bus_clk rise; rx_count=3 with PAR8_STATS_EN, 0 without.
REQ-038 Before sync, toggle bus_clk with data 8'h01 -> no rx_valid; drive B8, 12, 8B -> stays UNSYNC; then B8, 8B -> synced.
REQ-039 Set bus_rnw=1 with tx_valid=1 and tx_data=8'hA5; pulse bus_clk -> tx_ready pulses once, bus_data_out=A5 and oe=1 before the bus_clk rise; tx_count=1 with PAR8_STATS_EN.
REQ-040 Read with tx_valid=0 -> bus_data_out=00, tx_underrun=1 and held, tx_ready never asserts.
REQ-041 Assert reset between a bus_clk fall and rise -> no rx_valid and all outputs 0; after release, bus writes are ignored until resync.

Source files
------------

// File: rtl/par8_slave.sv
// -----------------------------------------------------------------------------
// par8_slave
//
// Slave side of the par8 byte-wide strobe bus. The master drives a slow strobe
// (bus_clk), a direction bit (bus_rnw) and a data byte, all asynchronous to
// clk. Every pin is brought into the clk domain by a 2-flop synchronizer. The
// strobe edges are recovered from one further register.
//
// The link has to be framed before any data moves. A small FSM watches the
// write data while the strobe is high. It looks for SYNC0 followed by SYNC1.
// Once it is SYNCED it stays there until reset.
//   - Write: a rising strobe edge with rnw=0 captures a byte. The byte appears
//     on rx_data together with a one-cycle rx_valid pulse.
//   - Read: a falling strobe edge with rnw=1 loads bus_data_out.
//       * If tx_valid is high, the byte comes from tx_data and tx_ready pulses.
//       * If tx_valid is low, the byte is 8'h00 and tx_underrun is set. The
//         underrun flag is sticky until reset.
//
// Build option:
//   PAR8_STATS_EN  When defined, rx_count and tx_count are live 16-bit
//                  wrapping byte counters. When undefined, both outputs are
//                  tied to zero.
//
// Parameters:
//   SYNC0, SYNC1   The two framing bytes, expected in this order.
//
// Ports:
//   clk            System clock
//   reset          Asynchronous reset, active low
//   bus_clk        Strobe from the master (asynchronous)
//   bus_rnw        Direction from the master: 1 = master reads, 0 = master writes
//   bus_data_in    Byte from the master pads
//   bus_data_out   Byte driven toward the master pads
//   bus_data_oe    Enable for the external pad tristate buffer
//   synced         High while the framing sequence has been seen
//   rx_data        Last byte received
//   rx_valid       One-cycle strobe that qualifies rx_data
//   tx_data        Byte offered for the next master read
//   tx_valid       tx_data holds a byte
//   tx_ready       One-cycle strobe: tx_data was taken this cycle
//   tx_underrun    Sticky flag: a read found tx_valid low
//   rx_count       Count of received bytes (zero unless PAR8_STATS_EN)
//   tx_count       Count of transmitted bytes (zero unless PAR8_STATS_EN)
// -----------------------------------------------------------------------------
module par8_slave #(
    parameter logic [7:0] SYNC0 = 8'hB8,
    parameter logic [7:0] SYNC1 = 8'h8B
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_clk,
    input  logic        bus_rnw,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    output logic        bus_data_oe,
    output logic        synced,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx_underrun,
    output logic [15:0] rx_count,
    output logic [15:0] tx_count
);

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        SAW0   = 2'd1,
        SYNCED = 2'd2
    } sync_state_t;

    // -------------------------------------------------------------------------
    // Input synchronizers
    // -------------------------------------------------------------------------
    logic       clk_meta_reg;
    logic       s_clk_reg;
    logic       s_clk_d_reg;   // third stage on the strobe, used only for edge detection
    logic       rnw_meta_reg;
    logic       s_rnw_reg;
    logic [7:0] s_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_meta_reg <= 1'b0;
            s_clk_reg    <= 1'b0;
            s_clk_d_reg  <= 1'b0;
            rnw_meta_reg <= 1'b0;
            s_rnw_reg    <= 1'b0;
        end else begin
            clk_meta_reg <= bus_clk;
            s_clk_reg    <= clk_meta_reg;
            s_clk_d_reg  <= s_clk_reg;
            rnw_meta_reg <= bus_rnw;
            s_rnw_reg    <= rnw_meta_reg;
        end
    end

    // The data byte is synchronized bit by bit. The master holds the data
    // stable around the strobe edge that samples it. The strobe and the data
    // go through the same number of stages, so any skew between bits has
    // settled before a sampling edge is seen.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_data_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= bus_data_in[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign s_data[gi] = sync_reg;
        end
    endgenerate

    logic clk_rise;
    logic clk_fall;

    assign clk_rise =  s_clk_reg && !s_clk_d_reg;
    assign clk_fall = !s_clk_reg &&  s_clk_d_reg;

    // -------------------------------------------------------------------------
    // Framing FSM and bus transfer logic
    // -------------------------------------------------------------------------
    sync_state_t state_reg;
    logic [7:0]  rx_data_reg;
    logic        rx_valid_reg;
    logic [7:0]  bus_data_out_reg;
    logic        bus_data_oe_reg;
    logic        tx_ready_reg;
    logic        tx_underrun_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= UNSYNC;
            rx_data_reg      <= 8'h00;
            rx_valid_reg     <= 1'b0;
            bus_data_out_reg <= 8'h00;
            bus_data_oe_reg  <= 1'b0;
            tx_ready_reg     <= 1'b0;
            tx_underrun_reg  <= 1'b0;
        end else begin
            rx_valid_reg    <= 1'b0;
            tx_ready_reg    <= 1'b0;
            bus_data_oe_reg <= s_rnw_reg && (state_reg == SYNCED);

            // The FSM checks the data level while the strobe is high. It does
            // not wait for an edge. A master that holds the strobe high and
            // only changes the data can therefore still frame the link.
            if (s_clk_reg && !s_rnw_reg) begin
                case (state_reg)
                    UNSYNC: begin
                        if (s_data == SYNC0) begin
                            state_reg <= SAW0;
                        end
                    end
                    SAW0: begin
                        if (s_data == SYNC1) begin
                            state_reg <= SYNCED;
                        end else if (s_data != SYNC0) begin
                            state_reg <= UNSYNC;
                        end
                    end
                    SYNCED: begin
                        state_reg <= SYNCED;
                    end
                    default: begin
                        state_reg <= UNSYNC;
                    end
                endcase
            end

            // These tests use the current state, not the next one. The edge
            // that completes framing is therefore not reported as a data byte.
            if (state_reg == SYNCED) begin
                if (clk_rise && !s_rnw_reg) begin
                    rx_data_reg  <= s_data;
                    rx_valid_reg <= 1'b1;
                end

                if (clk_fall && s_rnw_reg) begin
                    if (tx_valid) begin
                        bus_data_out_reg <= tx_data;
                        tx_ready_reg     <= 1'b1;
                    end else begin
                        bus_data_out_reg <= 8'h00;
                        tx_underrun_reg  <= 1'b1;
                    end
                end
            end
        end
    end

    assign synced       = (state_reg == SYNCED);
    assign rx_data      = rx_data_reg;
    assign rx_valid     = rx_valid_reg;
    assign bus_data_out = bus_data_out_reg;
    assign bus_data_oe  = bus_data_oe_reg;
    assign tx_ready     = tx_ready_reg;
    assign tx_underrun  = tx_underrun_reg;

    // -------------------------------------------------------------------------
    // Optional byte counters
    // -------------------------------------------------------------------------
`ifdef PAR8_STATS_EN
    logic [15:0] rx_count_reg;
    logic [15:0] tx_count_reg;

    // Each counter steps on the cycle after its strobe. Both wrap naturally
    // from 16'hFFFF to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_count_reg <= 16'h0000;
            tx_count_reg <= 16'h0000;
        end else begin
            if (rx_valid_reg) begin
                rx_count_reg <= rx_count_reg + 16'd1;
            end
            if (tx_ready_reg) begin
                tx_count_reg <= tx_count_reg + 16'd1;
            end
        end
    end

    assign rx_count = rx_count_reg;
    assign tx_count = tx_count_reg;
`else
    assign rx_count = 16'h0000;
    assign tx_count = 16'h0000;
`endif

endmodule

// File: tb/tb_par8_slave.sv
// -----------------------------------------------------------------------------
// tb_par8_slave
//
// Directed testbench for par8_slave. Each scenario task drives the bus pins
// and compares the outputs against hand-computed values. Outputs are sampled
// 1 ns after the rising clk edge.
// -----------------------------------------------------------------------------
module tb_par8_slave;

`ifdef PAR8_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        bus_clk;
    logic        bus_rnw;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic        bus_data_oe;
    logic        synced;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_underrun;
    logic [15:0] rx_count;
    logic [15:0] tx_count;

    int checks   = 0;
    int failures = 0;
    int rx_pulses = 0;
    int tx_pulses = 0;

    par8_slave #(
        .SYNC0(8'hB8),
        .SYNC1(8'h8B)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_clk     (bus_clk),
        .bus_rnw     (bus_rnw),
        .bus_data_in (bus_data_in),
        .bus_data_out(bus_data_out),
        .bus_data_oe (bus_data_oe),
        .synced      (synced),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_underrun (tx_underrun),
        .rx_count    (rx_count),
        .tx_count    (tx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every strobe cycle, so that a test can tell whether any strobe
    // fired in a window.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_pulses++;
        if (tx_ready === 1'b1) tx_pulses++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one master write: strobe low with the data for 3 clk, then
    // strobe high. Returns the clk count from the strobe rise to rx_valid
    // (0 if no pulse seen), and the byte captured at that point.
    task automatic bus_write(input logic [7:0] b, output int lat, output logic [7:0] d);
        bus_rnw     = 1'b0;
        bus_data_in = b;
        bus_clk     = 1'b0;
        repeat (3) tick();
        bus_clk = 1'b1;
        lat = 0;
        d   = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (rx_valid === 1'b1 && lat == 0) begin
                lat = k;
                d   = rx_data;
            end
        end
    endtask

    task automatic test_reset();
        logic [52:0] obs;
        reset = 1'b0; bus_clk = 1'b0; bus_rnw = 1'b0; bus_data_in = 8'h00;
        tx_data = 8'h00; tx_valid = 1'b0;
        repeat (4) tick();
        obs = {synced, rx_valid, tx_ready, tx_underrun, bus_data_oe,
               rx_data, bus_data_out, rx_count, tx_count};
        checks++;
        if (obs !== 53'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if (synced !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_unsynced: synced=%b want 0", synced);
        end
        $display("test_reset done");
    endtask

    task automatic test_sync();
        int rx0;
        rx0 = rx_pulses;
        bus_rnw = 1'b0; bus_data_in = 8'hB8; bus_clk = 1'b1;
        repeat (3) tick();
        checks++;
        if (synced !== 1'b0) begin
            failures++;
            $display("FAIL sync_early: synced=%b want 0 after SYNC0 only", synced);
        end
        bus_data_in = 8'h8B;
        repeat (3) tick();
        checks++;
        if (synced !== 1'b1) begin
            failures++;
            $display("FAIL sync_detect: synced=%b want 1 within 3 clk of 8B", synced);
        end
        tick();
        checks++;
        if (rx_pulses != rx0) begin
            failures++;
            $display("FAIL sync_no_rx: rx_valid pulses=%0d want 0", rx_pulses - rx0);
        end
        $display("test_sync synced=%b", synced);
    endtask

    task automatic test_write();
        logic [7:0] vec [3];
        int lat;
        logic [7:0] d;
        vec[0] = 8'h05; vec[1] = 8'h00; vec[2] = 8'hB8;
        for (int i = 0; i < 3; i++) begin
            bus_write(vec[i], lat, d);
            checks++;
            if (lat != 3 || d !== vec[i]) begin
                failures++;
                $display("FAIL write_%0d: latency=%0d data=%h want latency=3 data=%h", i, lat, d, vec[i]);
            end
            $display("write %0d data=%h latency=%0d", i, d, lat);
        end
        tick();
        checks++;
        if (rx_count !== (STATS ? 16'd3 : 16'd0)) begin
            failures++;
            $display("FAIL write_rx_count: got %0d want %0d", rx_count, STATS ? 3 : 0);
        end
    endtask

    task automatic test_read();
        int tx0;
        int rx0;
        int lat;
        logic [7:0] d;
        tx0 = tx_pulses; rx0 = rx_pulses;
        tx_data = 8'hA5; tx_valid = 1'b1; bus_rnw = 1'b1;
        repeat (4) tick();
        checks++;
        if (bus_data_oe !== 1'b1 || tx_pulses != tx0) begin
            failures++;
            $display("FAIL read_oe_on: oe=%b tx_ready pulses=%0d want oe=1 pulses=0", bus_data_oe, tx_pulses - tx0);
        end
        bus_clk = 1'b0;
        lat = 0; d = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (tx_ready === 1'b1 && lat == 0) begin
                lat = k;
                d   = bus_data_out;
            end
        end
        checks++;
        if (lat != 3 || d !== 8'hA5) begin
            failures++;
            $display("FAIL read_strobe: latency=%0d data=%h want latency=3 data=a5", lat, d);
        end
        tx_valid = 1'b0;
        checks++;
        if (bus_data_out !== 8'hA5 || bus_data_oe !== 1'b1 || tx_pulses - tx0 != 1 || tx_underrun !== 1'b0) begin
            failures++;
            $display("FAIL read_before_rise: out=%h oe=%b pulses=%0d underrun=%b want a5 1 1 0",
                     bus_data_out, bus_data_oe, tx_pulses - tx0, tx_underrun);
        end
        bus_clk = 1'b1;
        repeat (4) tick();
        checks++;
        if (bus_data_out !== 8'hA5 || rx_pulses != rx0 || tx_pulses - tx0 != 1) begin
            failures++;
            $display("FAIL read_rise_ignored: out=%h rx pulses=%0d tx pulses=%0d want a5 0 1",
                     bus_data_out, rx_pulses - rx0, tx_pulses - tx0);
        end
        checks++;
        if (tx_count !== (STATS ? 16'd1 : 16'd0)) begin
            failures++;
            $display("FAIL read_tx_count: got %0d want %0d", tx_count, STATS ? 1 : 0);
        end
        $display("read data=%h latency=%0d", d, lat);
    endtask

    task automatic test_underrun();
        int tx0;
        int dropped;
        tx0 = tx_pulses;
        tx_data = 8'h5A; tx_valid = 1'b0;
        bus_clk = 1'b0;
        repeat (5) tick();
        checks++;
        if (bus_data_out !== 8'h00 || tx_underrun !== 1'b1 || tx_pulses != tx0) begin
            failures++;
            $display("FAIL underrun_read: out=%h underrun=%b tx pulses=%0d want 00 1 0",
                     bus_data_out, tx_underrun, tx_pulses - tx0);
        end
        bus_clk = 1'b1;
        repeat (4) tick();
        bus_rnw = 1'b0;
        dropped = 0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (bus_data_oe === 1'b0 && dropped == 0) dropped = k;
        end
        checks++;
        if (dropped == 0) begin
            failures++;
            $display("FAIL oe_drop: oe=%b still set 3 clk after rnw fell, want 0", bus_data_oe);
        end
        checks++;
        if (tx_underrun !== 1'b1 || tx_count !== (STATS ? 16'd1 : 16'd0)) begin
            failures++;
            $display("FAIL underrun_sticky: underrun=%b tx_count=%0d want 1 %0d",
                     tx_underrun, tx_count, STATS ? 1 : 0);
        end
        $display("underrun out=%h flag=%b oe_drop_clk=%0d", bus_data_out, tx_underrun, dropped);
    endtask

    task automatic test_presync();
        logic [7:0] vec [7];
        logic [6:0] want_sync;
        int lat;
        logic [7:0] d;
        int bad;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        vec[0] = 8'h01; vec[1] = 8'h01; vec[2] = 8'hB8; vec[3] = 8'h12;
        vec[4] = 8'h8B; vec[5] = 8'hB8; vec[6] = 8'h8B;
        want_sync = 7'b1000000;  // bit i: synced expected after write i
        for (int i = 0; i < 7; i++) begin
            bus_write(vec[i], lat, d);
            bad = (lat != 0 || synced !== want_sync[i]) ? 1 : 0;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL presync_%0d: data=%h rx latency=%0d synced=%b want latency=0 synced=%b",
                         i, vec[i], lat, synced, want_sync[i]);
            end
            $display("presync %0d data=%h synced=%b", i, vec[i], synced);
        end
        checks++;
        if (rx_count !== 16'd0) begin
            failures++;
            $display("FAIL presync_rx_count: got %0d want 0", rx_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [52:0] obs;
        int rx0;
        int lat;
        logic [7:0] d;
        bus_write(8'h5C, lat, d);
        checks++;
        if (lat != 3 || d !== 8'h5C || rx_data !== 8'h5C) begin
            failures++;
            $display("FAIL mid_prewrite: latency=%0d data=%h want 3 5c", lat, d);
        end
        rx0 = rx_pulses;
        bus_data_in = 8'h77; bus_clk = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        obs = {synced, rx_valid, tx_ready, tx_underrun, bus_data_oe,
               rx_data, bus_data_out, rx_count, tx_count};
        checks++;
        if (obs !== 53'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got %h want 0", obs);
        end
        tick();
        bus_clk = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        repeat (4) tick();
        checks++;
        if (rx_pulses != rx0 || synced !== 1'b0) begin
            failures++;
            $display("FAIL mid_abort: rx pulses=%0d synced=%b want 0 0", rx_pulses - rx0, synced);
        end
        bus_write(8'h33, lat, d);
        checks++;
        if (lat != 0 || synced !== 1'b0 || rx_data !== 8'h00) begin
            failures++;
            $display("FAIL mid_needs_resync: latency=%0d synced=%b rx_data=%h want 0 0 00", lat, synced, rx_data);
        end
        $display("reset_mid synced=%b rx_data=%h", synced, rx_data);
    endtask

    initial begin
        test_reset();
        test_sync();
        test_write();
        test_read();
        test_underrun();
        test_presync();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
